// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and round-robin pick helper for adder_arbiter
package adder_arb_pkg;

    typedef enum logic {S_EMPTY, S_FULL} arb_state_e;

    localparam int MAX_REQ  = 32;
    localparam int ID_MAX_W = 5;

    // First set bit of valid scanning ptr, ptr+1, ... mod n; caller checks that any bit is set.
    function automatic logic [ID_MAX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [ID_MAX_W-1:0] ptr,
        input logic [ID_MAX_W:0]   n
    );
        logic [ID_MAX_W-1:0] pick;
        int                  idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(n);
            if (k < int'(n) && valid[idx[ID_MAX_W-1:0]]) begin
                pick = idx[ID_MAX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational WIDTH-bit adder shared by the arbiter
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot round-robin grant from request valids and a rotating pointer
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    logic [ID_MAX_W-1:0] pick;

    assign pick     = rr_pick(MAX_REQ'(valid), ID_MAX_W'(ptr), (ID_MAX_W + 1)'(N_REQ));
    assign grant_id = ID_W'(pick);
    assign any      = |valid;
    assign grant    = (enable && any) ? (N_REQ'(1) << grant_id) : '0;

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one adder with a registered response slot
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_carry,
    output logic [CNT_W-1:0]       op_count
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH-1:0] a_sel, b_sel, sum;

    assign slot_free = (state_q == S_EMPTY) || rsp_ready;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .valid    (req_valid),
        .ptr      (rr_ptr_q),
        .enable   (slot_free && rst_n),
        .grant    (req_ready),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    assign a_sel = req_a[grant_id*WIDTH +: WIDTH];
    assign b_sel = req_b[grant_id*WIDTH +: WIDTH];

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    assign xfer      = |(req_valid & req_ready);
    assign rsp_valid = (state_q == S_FULL);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            state_d  = S_FULL;
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (state_q == S_FULL && rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            rr_ptr_q   <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                rsp_id     <= grant_id;
                rsp_result <= sum;
                rsp_carry  <= (sum < a_sel);
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    // grant_any is only informative here; the grant vector already folds it in.
    logic unused_any;
    assign unused_any = grant_any;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter against a reference model
module tb_adder_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_carry;
    logic [CNT_W-1:0]       op_count;

    adder_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: response slot contents, rotation start and handshake count.
    logic             m_full;
    logic [1:0]       m_id;
    logic [WIDTH-1:0] m_res;
    logic             m_carry;
    int               m_ptr;
    logic [CNT_W-1:0] m_cnt;
    logic [N_REQ-1:0] last_grant;
    logic [1:0]       ids [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_id    = '0;
        m_res   = '0;
        m_carry = 1'b0;
        m_ptr   = 0;
        m_cnt   = '0;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Called at a negedge with inputs already driven; ends at the following negedge.
    task automatic tick();
        logic [N_REQ-1:0] er;
        logic [8:0]       s;
        int               g;
        int               idx;
        #1;
        er = '0;
        g  = -1;
        if (rst_n && (!m_full || rsp_ready)) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        last_grant = er;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_full && rsp_ready) m_cnt = m_cnt + 1'b1;
            if (g >= 0) begin
                s       = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
                m_full  = 1'b1;
                m_id    = 2'(g);
                m_res   = s[7:0];
                m_carry = s[8];
                m_ptr   = (g + 1) % N_REQ;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        check("op_count", 32'(op_count), 32'(m_cnt));
    endtask

    task automatic single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_r, input logic exp_c);
        req_valid = 4'b0001;
        set_op(0, a, b);
        rsp_ready = 1'b1;
        tick();
        check("t3_result", 32'(rsp_result), 32'(exp_r));
        check("t3_carry", 32'(rsp_carry), 32'(exp_c));
        req_valid = '0;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        last_grant = '0;
        @(negedge clk);

        // 1: reset with all requesters asking
        tick();
        tick();
        check("t1_ready", 32'(req_ready), 32'h0);
        check("t1_valid", 32'(rsp_valid), 32'h0);
        check("t1_count", 32'(op_count), 32'h0);
        rst_n     = 1'b1;
        req_valid = '0;
        tick();

        // 2: single request from requester 2
        req_valid = 4'b0100;
        set_op(2, 8'h0F, 8'h0F);
        rsp_ready = 1'b1;
        tick();
        check("t2_valid", 32'(rsp_valid), 32'h1);
        check("t2_id", 32'(rsp_id), 32'h2);
        check("t2_result", 32'(rsp_result), 32'h1E);
        check("t2_carry", 32'(rsp_carry), 32'h0);
        req_valid = '0;
        tick();
        check("t2_count", 32'(op_count), 32'h1);

        // 3: carry and wrap-around corners
        single(8'hFF, 8'h01, 8'h00, 1'b1);
        single(8'hFF, 8'hFF, 8'hFE, 1'b1);
        single(8'h55, 8'hAA, 8'hFF, 1'b0);

        // 4: round robin from a fresh pointer, no bubbles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_op(i, 8'(i * 16 + 3), 8'(i + 200));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_valid", 32'(rsp_valid), 32'h1);
            ids[k] = rsp_id;
        end
        check("t4_id0", 32'(ids[0]), 32'h0);
        check("t4_id1", 32'(ids[1]), 32'h1);
        check("t4_id2", 32'(ids[2]), 32'h2);
        check("t4_id3", 32'(ids[3]), 32'h3);
        check("t4_id4", 32'(ids[4]), 32'h0);

        // 5: backpressure holds the slot, then drain and grant together
        rsp_ready = 1'b0;
        tick();
        tick();
        check("t5_ready", 32'(req_ready), 32'h0);
        check("t5_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick();
        check("t5_refill", 32'(rsp_valid), 32'h1);

        // 6: reset while a response is pending
        rsp_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_valid", 32'(rsp_valid), 32'h0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("t6_id", 32'(rsp_id), 32'h0);

        // Random traffic obeying the request protocol; covers op_count wrap.
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    req_valid[i] = 1'b1;
                    set_op(i, 8'($urandom), 8'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            tick();
            req_valid = req_valid & ~last_grant;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
